// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit datapath among N_REQ byte producers.
// Latches the winning byte, holds tx_set for the frame and forces a one-cycle set drop after tx_done.
module uart_tx_sched #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*DW-1:0]   i_din,
  output logic [N_REQ-1:0]      o_ack,
  output logic [2:0]            o_gnt_id,
  output logic                  o_busy,
  output logic                  o_tx_sel,
  output logic                  o_tx_set,
  output logic [DW-1:0]         o_tx_din,
  input  logic                  i_tx_done,
  output logic [15:0]           o_frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_ptr;
  logic [2:0]          r_gnt_id;
  logic                r_busy;
  logic                r_tx_sel;
  logic                r_tx_set;
  logic [DW-1:0]       r_tx_din;
  logic [N_REQ-1:0]    r_ack;
  logic [15:0]         r_frame_cnt;

  logic [7:0]          w_req8;
  logic [3:0]          w_idx;
  logic                w_found;
  logic [2:0]          w_win;
  logic [2:0]          w_ptr_nxt;
  logic [DW-1:0]       w_win_byte;
  logic                w_grant;
  logic                w_frame_end;
  logic                w_tx_set_nxt;
  logic                w_busy_nxt;
  logic [N_REQ-1:0]    w_ack_nxt;

  // Search starts at r_ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin
    w_req8               = '0;
    w_req8[N_REQ-1:0]    = i_req;
    w_found              = 1'b0;
    w_win                = r_ptr;
    w_idx                = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + 4'(k);
      if (w_idx >= 4'(N_REQ)) w_idx = w_idx - 4'(N_REQ);
      if (!w_found && w_req8[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[2:0];
      end
    end
  end

  always_comb begin
    w_win_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == 3'(i)) w_win_byte = i_din[i*DW +: DW];
    end
  end

  assign w_ptr_nxt   = (w_win == 3'(N_REQ-1)) ? 3'd0 : w_win + 3'd1;
  assign w_grant     = (r_state == S_IDLE) && i_en && w_found;
  assign w_frame_end = (r_state == S_SEND) && i_en && i_tx_done;

  // Next-state logic; en low overrides everything and parks the FSM in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_found)   w_state_nxt = S_SEND;
        S_SEND:  if (i_tx_done) w_state_nxt = S_GAP;
        S_GAP:                  w_state_nxt = S_IDLE;
        default:                w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_tx_set_nxt = (w_state_nxt == S_SEND);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_ack_nxt    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ack_nxt[i] = w_grant && (w_win == 3'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt_id    <= '0;
      r_busy      <= 1'b0;
      r_tx_sel    <= 1'b0;
      r_tx_set    <= 1'b0;
      r_tx_din    <= '0;
      r_ack       <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= w_busy_nxt;
      r_tx_sel <= i_en;
      r_tx_set <= w_tx_set_nxt;
      r_ack    <= w_ack_nxt;
      if (w_grant) begin
        r_tx_din <= w_win_byte;
        r_gnt_id <= w_win;
        r_ptr    <= w_ptr_nxt;
      end
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_ack       = r_ack;
  assign o_gnt_id    = r_gnt_id;
  assign o_busy      = r_busy;
  assign o_tx_sel    = r_tx_sel;
  assign o_tx_set    = r_tx_set;
  assign o_tx_din    = r_tx_din;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmit datapath among `N_REQ` byte producers. It arbitrates pending requests, latches the winning byte and drives the transmitter's `sel`/`set`/data inputs for one 10-bit frame. It watches the frame-end indication and forces the one-cycle `set` drop the transmit controller needs to clear its bit counter. It sits between the SoC-side producers and the `uart_tx` bit controller/shifter.

## Interface
- `N_REQ`, default 4: number of requesters, from 2 to 8.
- `DW`, default 8: data byte width. Fixed at 8 for the UART frame.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous reset, active-high.
- `en`  in  1: scheduler/transmitter enable.
- `req`  in  N_REQ: level request per requester. Held until `ack`.
- `din`  in  N_REQ*DW: per-requester byte. Requester i occupies bits [i*DW +: DW]. Stable while `req[i]` is high.
- `ack`  out  N_REQ: one-cycle pulse. The byte from requester i has been latched.
- `gnt_id`  out  3: index of the current or last granted requester.
- `busy`  out  1: a frame is in flight (state SEND or GAP).
- `tx_sel`  out  1: transmitter select. Registered copy of `en`.
- `tx_set`  out  1: transmitter frame enable. Held high for the whole frame.
- `tx_din`  out  DW: latched byte presented to the transmitter.
- `tx_done`  in  1: from transmitter. High when its bit count has reached 10 (end of frame).
- `frame_cnt`  out  16: completed-frame counter. Wraps from 0xFFFF to 0.

## Operation
- States: IDLE, SEND, GAP.
- **IDLE**
  - `tx_set`=0.
  - If `en`=1 and `req`≠0, pick a winner by round-robin starting at `ptr`. `ptr` resets to 0, so requester 0 has highest priority after reset.
  - On the clock edge:
    - `tx_din` ← winner byte.
    - `gnt_id` ← winner.
    - `ack[winner]` ← 1.
    - `ptr` ← (winner+1) mod N_REQ.
    - `tx_set` ← 1.
    - Go to SEND.
- **SEND**
  - `tx_set`=1 and `tx_din` held constant.
  - When `tx_done`=1:
    - `tx_set` ← 0.
    - `frame_cnt` ← `frame_cnt`+1.
    - Go to GAP.
- **GAP**
  - Exactly one cycle with `tx_set`=0, which returns the transmitter's counter to 0.
  - Then go to IDLE.
- `ack` is high for exactly one cycle per accepted byte, and only one bit of `ack` is ever high.
- A requester whose `req` is still high in IDLE after its own frame is served again, but only after every other pending requester has had a turn.
- `en`=0 in any state:
  - Next cycle: `tx_set`=0, `tx_sel`=0, state IDLE.
  - An in-flight frame is aborted. `frame_cnt` is not incremented.
  - No new grant is made.
  - `ptr` and `tx_din` are retained.
- `tx_done` is ignored in IDLE and GAP.
- `req` bits that change while not granted are harmless. Arbitration samples `req` only in IDLE.

## Timing
- Reset values (all outputs):
  - `ack`=0, `gnt_id`=0, `busy`=0, `tx_sel`=0, `tx_set`=0, `tx_din`=0x00, `frame_cnt`=0.
  - Internal: `ptr`=0, state IDLE.
- Grant latency: `req` sampled high in IDLE at edge k. Then `ack`, `tx_set` and `busy` are all high in cycle k+1, and `tx_din` is valid in cycle k+1.
- Frame end: `tx_done` sampled high at edge m.
  - `tx_set`=0 in cycle m+1 (GAP).
  - IDLE in cycle m+2.
  - The earliest next `ack` is in cycle m+3.
- `busy` = (state≠IDLE), registered together with the state.
- `tx_sel` lags `en` by one cycle.
- Reset mid-frame behaves like an `en` drop, with `ptr` and `frame_cnt` also cleared.
- Reset has priority over every other input.

## Test plan
- Single requester (N_REQ=4):
  - Stimulus: `req`=0001, `din[0]`=0xA5, `tx_done` pulsed 20 cycles after `ack`.
  - Required: one `ack`=0001, `tx_din`=0xA5, `tx_set` high for 21 cycles then low for exactly 1 cycle, `frame_cnt`=1.
- All four requesting continuously:
  - Stimulus: `req`=1111 held, each frame closed by a `tx_done` pulse.
  - Required: grant order 0,1,2,3,0; `gnt_id` matches each `ack`; `frame_cnt`=5 after five frames.
- Pointer fairness:
  - Stimulus: requester 2 served last, then `req`=0101.
  - Required: requester 0 is granted next (the search starts at 3 and wraps to 0); requester 2 follows.
- Abort:
  - Stimulus: `en` dropped in the 5th SEND cycle.
  - Required: next cycle `tx_set`=0, `tx_sel`=0, `busy`=0; `frame_cnt` unchanged; re-enabling with `req` still set grants the next requester after `ptr`.
- Reset mid-frame:
  - Stimulus: `rst` asserted for 1 cycle during SEND.
  - Required: all outputs return to their reset values on the next cycle, and the next grant goes to requester 0.
- Spurious `tx_done`:
  - Stimulus: `tx_done` held high in IDLE with `req`=0.
  - Required: no state change, `frame_cnt` stays 0.
